// File: rtl/keypad_pkg.sv
// Types and helpers shared by the keypad scanner and its testbench.
package keypad_pkg;

    typedef enum logic [1:0] {RELEASED, PRESS_DEB, PRESSED, RELEASE_DEB} key_state_t;
    typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_res_t;

    function automatic int code_width(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous show-ahead FIFO; a pop frees a slot for a push in the same cycle.
module key_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   pop,
    output logic [WIDTH-1:0]       data_out,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW + 1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign data_out = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset && do_push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column strobing, per-scan key classification,
// press/release debounce with optional auto-repeat, and a key-code FIFO.
//
// state       | meaning
// RELEASED    | no key accepted; waiting for a single key
// PRESS_DEB   | same single key seen cnt consecutive scans
// PRESSED     | cand accepted; auto-repeat counting while held
// RELEASE_DEB | empty scans seen cnt consecutive times
module keypad_scanner import keypad_pkg::*; #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int REPEAT_SCANS   = 0,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    output logic [COLS-1:0]                col_drive,
    input  logic [ROWS-1:0]                row_sense,
    output logic                           key_valid,
    output logic [code_width(ROWS,COLS)-1:0] key_code,
    input  logic                           pop,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           overflow,
    input  logic                           clear_overflow
);
    localparam int CW  = code_width(ROWS, COLS);
    localparam int DW  = $clog2(SCAN_DIV);
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DBW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int RPW = $clog2(REPEAT_SCANS + 2);

    logic            run;
    logic [DW-1:0]   div;
    logic [CLW-1:0]  col;
    logic [ROWS-1:0] row_s1, row_s2;
    logic            sample, last_col;

    assign sample   = run && (div == DW'(SCAN_DIV - 1));
    assign last_col = (col == CLW'(COLS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            run    <= 1'b0;
            div    <= '0;
            col    <= '0;
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            run    <= 1'b1;
            row_s1 <= row_sense;
            row_s2 <= row_s1;
            if (run) begin
                if (sample) begin
                    div <= '0;
                    col <= last_col ? '0 : col + 1'b1;
                end else begin
                    div <= div + 1'b1;
                end
            end
        end
    end

    always_comb begin
        col_drive = '1;
        if (run) col_drive[col] = 1'b0;
    end

    // hits saturates at 2: anything beyond one key is a ghost-prone MULTI
    logic [1:0]    hits, acc_hits;
    logic [CW-1:0] hit_code, acc_code;

    always_comb begin
        hits     = (col == '0) ? 2'd0 : acc_hits;
        hit_code = (col == '0) ? '0 : acc_code;
        for (int r = 0; r < ROWS; r++) begin
            if (!row_s2[r]) begin
                if (hits == 2'd0) hit_code = CW'(r * COLS) + CW'(col);
                if (hits != 2'd2) hits = hits + 2'd1;
            end
        end
    end

    logic          eval;
    scan_res_t     scan_res;
    logic [CW-1:0] scan_code;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_hits  <= '0;
            acc_code  <= '0;
            eval      <= 1'b0;
            scan_res  <= NONE;
            scan_code <= '0;
        end else begin
            eval <= sample && last_col;
            if (sample) begin
                acc_hits <= hits;
                acc_code <= hit_code;
                if (last_col) begin
                    scan_res  <= (hits == 2'd0) ? NONE : (hits == 2'd1) ? SINGLE : MULTI;
                    scan_code <= hit_code;
                end
            end
        end
    end

    key_state_t     state, state_nx;
    logic [CW-1:0]  cand, cand_nx;
    logic [DBW-1:0] cnt, cnt_nx;
    logic [RPW-1:0] rep, rep_nx;
    logic           push_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RELEASED;
            cand  <= '0;
            cnt   <= '0;
            rep   <= '0;
        end else begin
            state <= state_nx;
            cand  <= cand_nx;
            cnt   <= cnt_nx;
            rep   <= rep_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        cnt_nx   = cnt;
        rep_nx   = rep;
        push_req = 1'b0;
        if (eval) begin
            case (state)
                RELEASED: begin
                    if (scan_res == SINGLE) begin
                        state_nx = PRESS_DEB;
                        cand_nx  = scan_code;
                        cnt_nx   = DBW'(1);
                    end
                end
                PRESS_DEB: begin
                    if (scan_res == SINGLE && scan_code == cand) begin
                        cnt_nx = cnt + 1'b1;
                        if (cnt_nx == DBW'(DEBOUNCE_SCANS)) begin
                            push_req = 1'b1;
                            state_nx = PRESSED;
                            rep_nx   = '0;
                        end
                    end else if (scan_res == SINGLE) begin
                        cand_nx = scan_code;
                        cnt_nx  = DBW'(1);
                    end else begin
                        state_nx = RELEASED;
                    end
                end
                PRESSED: begin
                    if (scan_res == NONE) begin
                        state_nx = RELEASE_DEB;
                        cnt_nx   = DBW'(1);
                    end else if (scan_res == SINGLE && scan_code == cand && REPEAT_SCANS > 0) begin
                        rep_nx = rep + 1'b1;
                        if (rep_nx == RPW'(REPEAT_SCANS)) begin
                            push_req = 1'b1;
                            rep_nx   = '0;
                        end
                    end else begin
                        rep_nx = '0;
                    end
                end
                RELEASE_DEB: begin
                    if (scan_res == NONE) begin
                        cnt_nx = cnt + 1'b1;
                        if (cnt_nx == DBW'(DEBOUNCE_SCANS)) state_nx = RELEASED;
                    end else begin
                        state_nx = PRESSED;
                        rep_nx   = '0;
                    end
                end
                default: state_nx = RELEASED;
            endcase
        end
    end

    logic fifo_full, fifo_empty, drop;

    key_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CW)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push_req),
        .data_in  (cand),
        .pop      (pop),
        .data_out (key_code),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign key_valid = !fifo_empty;
    assign drop      = push_req && fifo_full && !pop;

    always_ff @(posedge clock) begin
        if (reset)               overflow <= 1'b0;
        else if (drop)           overflow <= 1'b1;
        else if (clear_overflow) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Two scanners (repeat off / repeat every 5 scans) share one simulated keypad
// and are compared scan by scan against a key-level behavioural model.
module tb_keypad_scanner;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, pop, clear_overflow;
    logic [15:0] keys;
    logic [3:0]  col_drive  [2];
    logic [3:0]  row_sense  [2];
    logic        key_valid  [2];
    logic [3:0]  key_code   [2];
    logic [2:0]  fifo_count [2];
    logic        overflow   [2];

    int checks = 0;
    int errors = 0;

    // Physical keypad: a row reads low when a held key sits on a driven column.
    function automatic logic [3:0] sense(input logic [3:0] cd, input logic [15:0] k);
        logic [3:0] s;
        s = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!cd[c] && k[r*4+c]) s[r] = 1'b0;
        return s;
    endfunction

    assign row_sense[0] = sense(col_drive[0], keys);
    assign row_sense[1] = sense(col_drive[1], keys);

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
                     .REPEAT_SCANS(0), .FIFO_DEPTH(4)) dut0 (
        .clock(clock), .reset(reset), .col_drive(col_drive[0]), .row_sense(row_sense[0]),
        .key_valid(key_valid[0]), .key_code(key_code[0]), .pop(pop),
        .fifo_count(fifo_count[0]), .overflow(overflow[0]), .clear_overflow(clear_overflow));

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
                     .REPEAT_SCANS(5), .FIFO_DEPTH(4)) dut1 (
        .clock(clock), .reset(reset), .col_drive(col_drive[1]), .row_sense(row_sense[1]),
        .key_valid(key_valid[1]), .key_code(key_code[1]), .pop(pop),
        .fifo_count(fifo_count[1]), .overflow(overflow[1]), .clear_overflow(clear_overflow));

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model, one entry per instance.
    localparam int DEB = 3;
    int rep_cfg [2] = '{0, 5};
    int m_held [2], m_run [2], m_cand [2], m_nrun [2], m_rep [2];
    int m_q [2][4];
    int m_sz [2], m_ovf [2], m_pend [2], m_pcode [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_held[i] = 0; m_run[i] = 0; m_cand[i] = 0; m_nrun[i] = 0; m_rep[i] = 0;
            m_sz[i] = 0; m_ovf[i] = 0; m_pend[i] = 0; m_pcode[i] = 0;
        end
    endtask

    // Feed one completed scan's key set into the debounce rules.
    task automatic model_scan(input int i, input logic [15:0] k);
        int nk, code;
        nk = $countones(k);
        code = 0;
        for (int b = 0; b < 16; b++) if (k[b]) code = b;
        if (m_held[i] == 0) begin
            if (nk == 1) begin
                if (m_run[i] > 0 && code == m_cand[i]) m_run[i]++;
                else begin m_cand[i] = code; m_run[i] = 1; end
                if (m_run[i] == DEB) begin
                    m_pend[i] = 1; m_pcode[i] = code;
                    m_held[i] = 1; m_rep[i] = 0; m_nrun[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end else begin
            if (nk == 0) begin
                m_nrun[i]++;
                if (m_nrun[i] == DEB) begin m_held[i] = 0; m_run[i] = 0; end
            end else if (m_nrun[i] > 0) begin
                m_nrun[i] = 0; m_rep[i] = 0;
            end else if (nk == 1 && code == m_cand[i] && rep_cfg[i] > 0) begin
                m_rep[i]++;
                if (m_rep[i] == rep_cfg[i]) begin
                    m_pend[i] = 1; m_pcode[i] = m_cand[i]; m_rep[i] = 0;
                end
            end else begin
                m_rep[i] = 0;
            end
        end
    endtask

    // The clock edge where the previous scan's key (if any) lands in the FIFO.
    task automatic model_edge(input logic p, input logic clr);
        for (int i = 0; i < 2; i++) begin
            if (p && m_sz[i] > 0) begin
                for (int j = 0; j < 3; j++) m_q[i][j] = m_q[i][j+1];
                m_sz[i]--;
            end
            if (m_pend[i] != 0 && m_sz[i] == 4) m_ovf[i] = 1;
            else begin
                if (m_pend[i] != 0) begin m_q[i][m_sz[i]] = m_pcode[i]; m_sz[i]++; end
                if (clr) m_ovf[i] = 0;
            end
            m_pend[i] = 0;
        end
    endtask

    task automatic check_outputs(input string where);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("%s.valid%0d", where, i), int'(key_valid[i]), int'(m_sz[i] > 0));
            check_val($sformatf("%s.count%0d", where, i), int'(fifo_count[i]), m_sz[i]);
            check_val($sformatf("%s.ovf%0d", where, i), int'(overflow[i]), m_ovf[i]);
            if (m_sz[i] > 0)
                check_val($sformatf("%s.code%0d", where, i), int'(key_code[i]), m_q[i][0]);
        end
    endtask

    // Called just after the edge that starts a scan; pop/clear ride on cycle 0.
    task automatic do_scan(input logic [15:0] k, input logic p, input logic clr, input int ncyc);
        logic [3:0] exp_col;
        keys = k; pop = p; clear_overflow = clr;
        for (int j = 0; j < ncyc; j++) begin
            exp_col = ~(4'b0001 << (j / 4));
            check_val("col_drive0", int'(col_drive[0]), int'(exp_col));
            check_val("col_drive1", int'(col_drive[1]), int'(exp_col));
            @(posedge clock); #1;
            if (j == 0) begin
                pop = 1'b0; clear_overflow = 1'b0;
                model_edge(p, clr);
            end
        end
        if (ncyc == 16) for (int i = 0; i < 2; i++) model_scan(i, k);
    endtask

    task automatic apply_reset();
        reset = 1'b1; keys = '0; pop = 1'b0; clear_overflow = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_val("rst.col_drive", int'(col_drive[i]), 15);
            check_val("rst.key_valid", int'(key_valid[i]), 0);
            check_val("rst.key_code", int'(key_code[i]), 0);
            check_val("rst.fifo_count", int'(fifo_count[i]), 0);
            check_val("rst.overflow", int'(overflow[i]), 0);
        end
        model_reset();
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic press(input int code, input logic pop_on_push);
        for (int s = 0; s < 3; s++) begin do_scan(16'(1) << code, 0, 0, 16); check_outputs("press"); end
        do_scan('0, pop_on_push, 0, 16); check_outputs("press.rel");
        for (int s = 0; s < 2; s++) begin do_scan('0, 0, 0, 16); check_outputs("press.rel"); end
    endtask

    initial begin
        model_reset();
        apply_reset();

        // stable press of key 9
        for (int s = 0; s < 20; s++) begin do_scan(16'h0200, 0, 0, 16); check_outputs("stable"); end
        check_val("stable.count", int'(fifo_count[0]), 1);
        check_val("stable.code", int'(key_code[0]), 9);
        do_scan('0, 1, 0, 16); check_outputs("stable.pop");
        check_val("stable.popped", int'(key_valid[0]), 0);
        for (int s = 0; s < 3; s++) begin do_scan('0, 0, 0, 16); check_outputs("stable.rel"); end

        // bounce
        apply_reset();
        do_scan(16'h0200, 0, 0, 16); check_outputs("bounce");
        do_scan('0, 0, 0, 16);       check_outputs("bounce");
        do_scan(16'h0200, 0, 0, 16); check_outputs("bounce");
        do_scan(16'h0200, 0, 0, 16); check_outputs("bounce");
        for (int s = 0; s < 4; s++) begin do_scan('0, 0, 0, 16); check_outputs("bounce"); end
        check_val("bounce.count", int'(fifo_count[0]), 0);

        // ghosting: 0 and 5 together, then 5 alone
        for (int s = 0; s < 5; s++) begin do_scan(16'h0021, 0, 0, 16); check_outputs("ghost"); end
        check_val("ghost.none", int'(fifo_count[0]), 0);
        for (int s = 0; s < 4; s++) begin do_scan(16'h0020, 0, 0, 16); check_outputs("ghost5"); end
        check_val("ghost.code", int'(key_code[0]), 5);
        check_val("ghost.count", int'(fifo_count[0]), 1);

        // overflow
        apply_reset();
        press(1, 0); press(2, 0); press(3, 0); press(4, 0); press(6, 0);
        check_val("ovf.count", int'(fifo_count[0]), 4);
        check_val("ovf.flag", int'(overflow[0]), 1);
        for (int n = 1; n <= 4; n++) begin
            check_val("ovf.head", int'(key_code[0]), n);
            do_scan('0, 1, 0, 16); check_outputs("ovf.pop");
        end
        do_scan('0, 0, 1, 16); check_outputs("ovf.clr");
        check_val("ovf.cleared", int'(overflow[0]), 0);

        // push and pop together while full
        press(1, 0); press(2, 0); press(3, 0); press(4, 0);
        press(6, 1);
        check_val("full.count", int'(fifo_count[0]), 4);
        check_val("full.ovf", int'(overflow[0]), 0);
        check_val("full.head", int'(key_code[0]), 2);

        // auto-repeat with reset in scan 10
        apply_reset();
        for (int s = 0; s < 9; s++) begin do_scan(16'h0080, 0, 0, 16); check_outputs("rep"); end
        check_val("rep.count1", int'(fifo_count[1]), 2);
        check_val("rep.count0", int'(fifo_count[0]), 1);
        do_scan(16'h0080, 0, 0, 6);
        apply_reset();
        for (int s = 0; s < 4; s++) begin do_scan('0, 0, 0, 16); check_outputs("rep.post"); end
        check_val("rep.empty1", int'(fifo_count[1]), 0);

        // random traffic
        for (int it = 0; it < 40; it++) begin
            logic [15:0] k;
            int kind, hold, a, b;
            k = '0;
            kind = $urandom_range(0, 9);
            hold = $urandom_range(1, 6);
            a = $urandom_range(0, 15);
            b = (a + 1 + $urandom_range(0, 14)) % 16;
            if (kind >= 4) k[a] = 1'b1;
            if (kind == 9) k[b] = 1'b1;
            for (int s = 0; s < hold; s++) begin
                do_scan(k, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 16);
                check_outputs("rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
